// File: rtl/disp_page_sched_pkg.sv
// Shared definitions for the display page scheduler: FSM state encoding,
// page geometry and a counter-width helper.
package disp_page_sched_pkg;

    localparam int NUM_PAGES = 4;
    localparam int PAGE_W    = 16;
    localparam int IDX_W     = $clog2(NUM_PAGES);

    typedef enum logic {
        ST_SHOW  = 1'b0,
        ST_BLANK = 1'b1
    } state_t;

    typedef logic [PAGE_W-1:0] page_t;

    // Width of a counter that must hold 0..n-1; never narrower than one bit.
    function automatic int cntWidth(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/disp_page_sched_btn_debounce.sv
// Push-button conditioner: two-flop synchronizer, disagreement-count debounce
// and a one-cycle pulse on each accepted press.
module btn_debounce
    import disp_page_sched_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 1000000
) (
    input  logic CLK,
    input  logic Reset,
    input  logic btn_raw,
    output logic level,
    output logic rise_pulse
);

    localparam int                DCNT_W    = cntWidth(DEBOUNCE_CYCLES);
    localparam logic [DCNT_W-1:0] DCNT_LAST = DCNT_W'(DEBOUNCE_CYCLES - 1);

    logic              r_sync1;
    logic              r_sync2;
    logic              r_deb;
    logic              r_deb_d;
    logic [DCNT_W-1:0] r_dcnt;

    // The accepted level only flips after DEBOUNCE_CYCLES consecutive disagreeing samples.
    always_ff @(posedge CLK) begin
        if (Reset) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
            r_deb   <= 1'b0;
            r_deb_d <= 1'b0;
            r_dcnt  <= '0;
        end else begin
            r_sync1 <= btn_raw;
            r_sync2 <= r_sync1;
            r_deb_d <= r_deb;
            if (r_sync2 != r_deb) begin
                if (r_dcnt == DCNT_LAST) begin
                    r_deb  <= r_sync2;
                    r_dcnt <= '0;
                end else begin
                    r_dcnt <= r_dcnt + DCNT_W'(1);
                end
            end else begin
                r_dcnt <= '0;
            end
        end
    end

    assign level      = r_deb;
    assign rise_pulse = r_deb & ~r_deb_d;

endmodule

// File: rtl/disp_page_sched.sv
// Display page scheduler: scan-tick divider, debounced page stepping and a
// SHOW/BLANK FSM that blanks the seven-segment driver after each page change.
module disp_page_sched
    import disp_page_sched_pkg::*;
#(
    parameter int DIV_SCAN        = 262144,
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int BLANK_TICKS     = 8
) (
    input  logic              CLK,
    input  logic              Reset,
    input  logic              btn_page,
    input  logic [PAGE_W-1:0] page0_data,
    input  logic [PAGE_W-1:0] page1_data,
    input  logic [PAGE_W-1:0] page2_data,
    input  logic [PAGE_W-1:0] page3_data,
    output logic              scan_tick,
    output logic [PAGE_W-1:0] disp_data,
    output logic              clr,
    output logic [IDX_W-1:0]  page_idx
);

    localparam int                DIV_W      = cntWidth(DIV_SCAN);
    localparam logic [DIV_W-1:0]  DIV_LAST   = DIV_W'(DIV_SCAN - 1);
    localparam int                BCNT_W     = cntWidth(BLANK_TICKS);
    localparam logic [BCNT_W-1:0] BLANK_LAST = BCNT_W'(BLANK_TICKS - 1);

    logic [DIV_W-1:0]  r_div_cnt;
    logic              w_scan_tick;
    logic              w_btn_level;
    logic              w_btn_rise;
    logic              w_page_req;
    page_t             w_pages [NUM_PAGES];

    state_t            r_state;
    state_t            w_state_nxt;
    logic [IDX_W-1:0]  r_page_idx;
    logic [IDX_W-1:0]  w_idx_nxt;
    logic [BCNT_W-1:0] r_bcnt;
    logic [BCNT_W-1:0] w_bcnt_nxt;
    page_t             r_disp_data;
    page_t             w_data_nxt;
    logic              r_clr;

    assign w_scan_tick = (r_div_cnt == DIV_LAST);

    always_ff @(posedge CLK) begin
        if (Reset || w_scan_tick) begin
            r_div_cnt <= '0;
        end else begin
            r_div_cnt <= r_div_cnt + DIV_W'(1);
        end
    end

    btn_debounce #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_btn_debounce (
        .CLK        (CLK),
        .Reset      (Reset),
        .btn_raw    (btn_page),
        .level      (w_btn_level),
        .rise_pulse (w_btn_rise)
    );

    assign w_page_req = w_btn_rise & w_btn_level;

    always_comb begin
        w_pages[0] = page0_data;
        w_pages[1] = page1_data;
        w_pages[2] = page2_data;
        w_pages[3] = page3_data;
    end

    // A page request outranks a coincident scan tick, so the old snapshot stays put.
    always_comb begin
        w_state_nxt = r_state;
        w_idx_nxt   = r_page_idx;
        w_bcnt_nxt  = r_bcnt;
        w_data_nxt  = r_disp_data;
        case (r_state)
            ST_SHOW: begin
                if (w_page_req) begin
                    w_idx_nxt   = r_page_idx + IDX_W'(1);
                    w_bcnt_nxt  = '0;
                    w_state_nxt = ST_BLANK;
                end else if (w_scan_tick) begin
                    w_data_nxt = w_pages[r_page_idx];
                end
            end
            ST_BLANK: begin
                if (w_scan_tick) begin
                    if (r_bcnt == BLANK_LAST) begin
                        w_state_nxt = ST_SHOW;
                        w_data_nxt  = w_pages[r_page_idx];
                    end else begin
                        w_bcnt_nxt = r_bcnt + BCNT_W'(1);
                    end
                end
            end
            default: w_state_nxt = ST_SHOW;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (Reset) begin
            r_state     <= ST_SHOW;
            r_page_idx  <= '0;
            r_bcnt      <= '0;
            r_disp_data <= '0;
            r_clr       <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_page_idx  <= w_idx_nxt;
            r_bcnt      <= w_bcnt_nxt;
            r_disp_data <= w_data_nxt;
            r_clr       <= (w_state_nxt == ST_BLANK);
        end
    end

    assign scan_tick = w_scan_tick;
    assign disp_data = r_disp_data;
    assign clr       = r_clr;
    assign page_idx  = r_page_idx;

endmodule

// File: doc/disp_page_sched.md
# disp_page_sched

Display page scheduler for the board's 4-digit seven-segment display driver. It divides the system clock into a digit-scan tick and selects one of four 16-bit CPU debug pages to present as the driver's `disp_data`. A debounced push-button steps through the pages. Each page change blanks the display through the driver's `clr` input for a fixed number of scan ticks.

## Interface
Parameters:
- `DIV_SCAN`, default 262144: system clocks per scan tick; must be ≥2.
- `DEBOUNCE_CYCLES`, default 1000000: consecutive stable synchronized cycles before a button level is accepted; must be ≥1.
- `BLANK_TICKS`, default 8: scan ticks spent blanked after a page change; must be ≥1.

Ports:
- `CLK` in 1: system clock. Single clock domain.
- `Reset` in 1: synchronous, active-high.
- `btn_page` in 1: raw, asynchronous page-advance button.
- `page0_data`..`page3_data` in 16 each: page sources, e.g. PC/next-PC, rs/rt, ALU result/DB.
- `scan_tick` out 1: one-`CLK` pulse that advances the driver's digit rotation.
- `disp_data` out 16: registered snapshot fed to the display driver.
- `clr` out 1: blank request to the driver; 1 shows all digits blank.
- `page_idx` out 2: currently selected page.

## Operation
- **Scan divider**
  - Free-running counter `div_cnt` runs 0..`DIV_SCAN`-1 and wraps.
  - `scan_tick` is 1 in the cycle where `div_cnt == DIV_SCAN-1`.
  - Period is exactly `DIV_SCAN` cycles.
- **Debounce**
  - Two-flop synchronizer produces `sync1`, then `sync2`.
  - `deb` is the accepted button level; `dcnt` counts disagreement.
  - At each edge where `sync2 != deb`: if `dcnt == DEBOUNCE_CYCLES-1`, then `deb <= sync2` and `dcnt <= 0`; otherwise `dcnt` increments.
  - At each edge where `sync2 == deb`: `dcnt <= 0`.
  - `page_req = deb & ~deb_d`, where `deb_d` is `deb` delayed one cycle. This gives one pulse per accepted press. Releases generate nothing.
- **FSM with states SHOW and BLANK**
  - **SHOW, `page_req`=1:** `page_idx <= page_idx+1`, wrapping 3→0. `bcnt <= 0`. Go to BLANK. `disp_data` holds. This applies even if `scan_tick` is also 1 in that cycle.
  - **SHOW, `page_req`=0, `scan_tick`=1:** `disp_data <= page[page_idx]`. The snapshot changes only on scan boundaries.
  - **BLANK, `scan_tick`=1:**
    - If `bcnt == BLANK_TICKS-1`: go to SHOW and load `disp_data <= page[page_idx]`, using the new index.
    - Otherwise `bcnt` increments.
  - **BLANK, `page_req`=1:** dropped. The index does not change.
  - `clr` is a registered output: 1 exactly while the state is BLANK.
- **Reset values:**
  - State SHOW; `page_idx`=0; `disp_data`=16'h0000; `clr`=0.
  - `div_cnt`=0, `dcnt`=0, `bcnt`=0.
  - `sync1`, `sync2`, `deb`, `deb_d` = 0.
- **Reset mid-operation:** aborts BLANK and returns to the reset values. If the button is still held after reset, it is re-debounced from 0 and produces one new advance.

## Timing
- First `scan_tick` after `Reset` deasserts: the cycle after edge `DIV_SCAN-1`, counted from the first edge with `Reset`=0.
- Press latency: if `btn_page` rises before edge k, `deb` rises at edge k+1+`DEBOUNCE_CYCLES`. `page_idx` changes and `clr` rises at edge k+2+`DEBOUNCE_CYCLES`.
- Blank duration: `clr` falls on the edge that consumes the `BLANK_TICKS`-th `scan_tick` after entering BLANK. `disp_data` updates on that same edge.
- Glitches shorter than `DEBOUNCE_CYCLES` synchronized cycles never change `deb`.
- `disp_data`, `clr` and `page_idx` are all registered, with no combinational path from any input.

## Structure
- Shared display package holds:
  - state encoding `ST_SHOW`=1'b0, `ST_BLANK`=1'b1;
  - `NUM_PAGES`=4;
  - page width 16.
- Sub-module `btn_debounce`, parameter `DEBOUNCE_CYCLES`:
  - ports `CLK`, `Reset`, `btn_raw`, `level`, `rise_pulse`;
  - contains the synchronizer, `dcnt` and edge detect.
- Top level contains the scan divider, FSM and page mux.

## Test plan
All scenarios use `DIV_SCAN`=4, `DEBOUNCE_CYCLES`=3, `BLANK_TICKS`=2, with pages = 16'h1111, 16'h2222, 16'h3333, 16'h4444.
- **Reset and divider:** hold `Reset` 3 cycles then release → `scan_tick` pulses every 4 cycles, first after the 4th edge. `disp_data` becomes 16'h1111 on the first tick. `clr`=0 and `page_idx`=0 throughout.
- **Press latency and blank:** press `btn_page` before edge k and hold → `page_idx`=1 and `clr`=1 at edge k+5. After 2 `scan_tick`s, `clr`=0 and `disp_data`=16'h2222 on the same edge.
- **Glitch rejection:** 2-cycle pulse on `btn_page` → `page_idx` stays 0 and `clr` stays 0.
- **Wrap and drop:**
  - 4 clean presses spaced beyond the blank window → `page_idx` goes 1, 2, 3, 0 and `disp_data` ends at 16'h1111.
  - A second press accepted during BLANK → no extra increment.
- **Tick/request collision:** align `page_req` with `scan_tick` in SHOW → index advances, `disp_data` keeps its old value, `clr` rises.
- **Reset mid-blank:** assert `Reset` while `clr`=1 with button held → next edge `clr`=0, `page_idx`=0, `disp_data`=0. After release, `page_idx`=1 exactly 5 edges after the first edge with `Reset`=0, and `clr`=1 at that edge.
